// File: rtl/addsub_operand_seq.sv
// Operand sequencer for the two's-complement adder/subtractor.
// Steps A -> B/mode -> execute -> show on successive button presses,
// captures the adder's result and keeps saturating op/overflow counts.
//
// state  | meaning
// -------+-----------------------------------------------
// S_A    | waiting for press to latch operand A
// S_B    | waiting for press to latch operand B and mode
// S_EXEC | one cycle: capture sum/overflow, bump counters
// S_SHOW | result valid (done=1); press returns to S_A
module addsub_operand_seq #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             mode_sw,
  input  logic             btn,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             ovf_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_m,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_r;
  state_t state_nxt;
  logic   btn_q;
  logic   press;

  // btn_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_A;
    else     state_r <= state_nxt;
  end

  // Next-state logic; EXEC always lasts exactly one cycle.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_A:     if (press) state_nxt = S_B;
      S_B:     if (press) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_SHOW;
      S_SHOW:  if (press) state_nxt = S_A;
      default: state_nxt = S_A;
    endcase
  end

  // Operand latching, result capture and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_m    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      op_cnt  <= '0;
      ovf_cnt <= '0;
    end else begin
      case (state_r)
        S_A: begin
          if (press) op_a <= sw;
        end
        S_B: begin
          if (press) begin
            op_b <= sw;
            op_m <= mode_sw;
          end
        end
        S_EXEC: begin
          result <= sum_in;
          ovf    <= ovf_in;
          done   <= 1'b1;
          if (op_cnt != CNT_MAX)            op_cnt  <= op_cnt + CNT_ONE;
          if (ovf_in && ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + CNT_ONE;
        end
        S_SHOW: begin
          if (press) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_addsub_operand_seq.sv
// Directed bench for addsub_operand_seq with a behavioural adder attached.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_addsub_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       mode_sw;
  logic       btn;

  logic [2:0] op_a, op_b, result, sum_in;
  logic       op_m, ovf, done, ovf_in;
  logic [1:0] state;
  logic [7:0] op_cnt, ovf_cnt;

  logic [2:0] op_a2, op_b2, result2, sum_in2;
  logic       op_m2, ovf2, done2, ovf_in2;
  logic [1:0] state2;
  logic [1:0] op_cnt2, ovf_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 3-bit two's-complement adder/subtractor: {ovf, sum}.
  function automatic logic [3:0] addsub(input logic [2:0] a, input logic [2:0] b, input logic m);
    logic [2:0] s;
    logic       v;
    s = m ? (a - b) : (a + b);
    if (m) v = (a[2] != b[2]) && (s[2] != a[2]);
    else   v = (a[2] == b[2]) && (s[2] != a[2]);
    return {v, s};
  endfunction

  always_comb {ovf_in, sum_in}   = addsub(op_a, op_b, op_m);
  always_comb {ovf_in2, sum_in2} = addsub(op_a2, op_b2, op_m2);

  addsub_operand_seq #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode_sw(mode_sw), .btn(btn),
    .sum_in(sum_in), .ovf_in(ovf_in),
    .op_a(op_a), .op_b(op_b), .op_m(op_m), .result(result), .ovf(ovf),
    .done(done), .state(state), .op_cnt(op_cnt), .ovf_cnt(ovf_cnt)
  );

  addsub_operand_seq #(.WIDTH(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sw(sw), .mode_sw(mode_sw), .btn(btn),
    .sum_in(sum_in2), .ovf_in(ovf_in2),
    .op_a(op_a2), .op_b(op_b2), .op_m(op_m2), .result(result2), .ovf(ovf2),
    .done(done2), .state(state2), .op_cnt(op_cnt2), .ovf_cnt(ovf_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle press; returns on the negedge after the press edge.
  task automatic press(input logic [2:0] val, input logic m);
    @(negedge clk);
    sw      = val;
    mode_sw = m;
    btn     = 1'b1;
    @(negedge clk);
    btn     = 1'b0;
    sw      = 3'b000;
    mode_sw = 1'b0;
  endtask

  // A press, B press, then wait for EXEC so the result is on display.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic m);
    press(a, 1'b0);
    press(b, m);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b1; sw = 3'b111; mode_sw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state",  state,   2'b00);
    chk("rst_op_a",   op_a,    0);
    chk("rst_op_b",   op_b,    0);
    chk("rst_op_m",   op_m,    0);
    chk("rst_result", result,  0);
    chk("rst_ovf",    ovf,     0);
    chk("rst_done",   done,    0);
    chk("rst_op_cnt", op_cnt,  0);
    chk("rst_ovfcnt", ovf_cnt, 0);
    btn = 1'b0; sw = 3'b000; mode_sw = 1'b0;
    @(negedge clk);

    // Held button gives exactly one press.
    sw = 3'b011; btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_state", state, 2'b01);
    chk("hold_op_a",  op_a,  3);
    btn = 1'b0;

    // Operand B: 3 + 2 overflows.
    press(3'b010, 1'b0);
    chk("b_op_b",  op_b,  2);
    chk("b_op_m",  op_m,  0);
    chk("b_state", state, 2'b10);
    @(negedge clk);
    chk("op1_result", result,  3'b101);
    chk("op1_ovf",    ovf,     1);
    chk("op1_done",   done,    1);
    chk("op1_state",  state,   2'b11);
    chk("op1_opcnt",  op_cnt,  1);
    chk("op1_ovfcnt", ovf_cnt, 1);
    repeat (3) @(negedge clk);
    chk("show_hold", result, 3'b101);

    press(3'b000, 1'b0);
    chk("back_state", state, 2'b00);
    chk("back_done",  done,  0);
    chk("back_keep",  result, 3'b101);

    // 2 - 3 = -1, no overflow.
    run_op(3'b010, 3'b011, 1'b1);
    chk("op2_result", result,  3'b111);
    chk("op2_ovf",    ovf,     0);
    chk("op2_opcnt",  op_cnt,  2);
    chk("op2_ovfcnt", ovf_cnt, 1);
    press(3'b000, 1'b0);

    // -4 - 1 overflows.
    run_op(3'b100, 3'b001, 1'b1);
    chk("op3_result", result,  3'b011);
    chk("op3_ovf",    ovf,     1);
    chk("op3_opcnt",  op_cnt,  3);
    chk("op3_ovfcnt", ovf_cnt, 2);
    press(3'b000, 1'b0);

    // Reset mid-sequence in S_B.
    press(3'b101, 1'b0);
    chk("midb_state", state, 2'b01);
    chk("midb_op_a",  op_a,  5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_state",  state,   2'b00);
    chk("mrst_op_a",   op_a,    0);
    chk("mrst_opcnt",  op_cnt,  0);
    chk("mrst_ovfcnt", ovf_cnt, 0);
    chk("mrst_done",   done,    0);

    // 1 + 1 after reset.
    run_op(3'b001, 3'b001, 1'b0);
    chk("op4_result", result,  3'b010);
    chk("op4_ovf",    ovf,     0);
    chk("op4_opcnt",  op_cnt,  1);
    chk("op4_ovfcnt", ovf_cnt, 0);
    press(3'b000, 1'b0);

    // Five overflowing ops: the 2-bit counters stop at 3.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_op(3'b011, 3'b010, 1'b0);
      press(3'b000, 1'b0);
    end
    chk("sat_opcnt",   op_cnt2,  3);
    chk("sat_ovfcnt",  ovf_cnt2, 3);
    chk("wide_opcnt",  op_cnt,   5);
    chk("wide_ovfcnt", ovf_cnt,  5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_operand_seq.md
Name: addsub_operand_seq

Overview:
- Front-end sequencer for the 3-bit two's-complement adder/subtractor datapath.
- Collects operand A, operand B and the mode bit from switches, one button press per step.
- Drives the combinational adder/subtractor with stable registered operands, then captures its sum and overflow into display registers.
- Keeps running counts of operations performed and overflows seen.

Parameters:
- WIDTH, 3: operand/result width; must match the adder/subtractor width.
- CNT_W, 8: width of the operation and overflow counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- sw  input  WIDTH  operand switches, sampled on a qualified button press.
- mode_sw  input  1  0 = add, 1 = subtract; sampled together with operand B.
- btn  input  1  step button, already debounced and level-type; edge detection is internal.
- sum_in  input  WIDTH  sum/difference returned by the adder/subtractor.
- ovf_in  input  1  overflow flag returned by the adder/subtractor.
- op_a  output  WIDTH  registered operand A to the adder/subtractor.
- op_b  output  WIDTH  registered operand B to the adder/subtractor.
- op_m  output  1  registered mode to the adder/subtractor.
- result  output  WIDTH  captured sum/difference.
- ovf  output  1  captured overflow.
- done  output  1  high while the captured result is valid for display.
- state  output  2  current FSM state, for LEDs.
- op_cnt  output  CNT_W  number of completed operations, saturating.
- ovf_cnt  output  CNT_W  number of completed operations with overflow, saturating.

Behaviour:
- Reset (rst=1 at a clock edge) forces the following:
  - state=S_A, and op_a, op_b, op_m, result, ovf, done, op_cnt, ovf_cnt all 0.
  - Internal btn_q=1, so a button held through reset does not produce a press.
  - Reset has priority over every other event, including mid-sequence (S_B, S_EXEC, S_SHOW): everything returns to the reset values.
- Press detect:
  - btn_q <= btn every cycle.
  - press = btn & ~btn_q, exactly one cycle per rising edge.
  - Holding btn produces one press only.
- State encoding: S_A=2'b00, S_B=2'b01, S_EXEC=2'b10, S_SHOW=2'b11.
- S_A: on press, op_a<=sw and go to S_B. Otherwise hold.
- S_B: on press, op_b<=sw, op_m<=mode_sw and go to S_EXEC. Otherwise hold.
- S_EXEC: exactly one cycle, press ignored.
  - result<=sum_in, ovf<=ovf_in, done<=1.
  - op_cnt<=op_cnt+1 unless all-ones.
  - ovf_cnt<=ovf_cnt+1 if ovf_in and not all-ones.
  - Go to S_SHOW.
- S_SHOW: hold result, ovf and done=1. On press, done<=0 and go to S_A.
  - result, ovf, op_a, op_b and op_m keep their values until overwritten by the next sequence.
- Latency:
  - sum_in depends combinationally on op_a/op_b/op_m, which are stable from the S_B press edge onward.
  - result/ovf are valid the cycle after S_EXEC, i.e. 2 clocks after the S_B press is registered.
- Operands are never modified outside S_A/S_B presses.
- sw and mode_sw changes are ignored outside a press cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- No arithmetic is done here. The overflow definition belongs to the adder: signed WIDTH-bit overflow.

Test Plan:
- Reset with btn held high, then release reset while btn stays high → no state change; state=00 and all outputs 0. Release btn, then press → state=01.
- sw=3 press, sw=2 mode_sw=0 press, with a behavioural adder model attached:
  - op_a=3, op_b=2, op_m=0.
  - Two cycles later result=3'b101, ovf=1, done=1, state=11, op_cnt=1, ovf_cnt=1.
- Next press → state=00, done=0. Then A=2, B=3, mode=1 → result=3'b111, ovf=0, op_cnt=2, ovf_cnt=1.
- A=3'b100, B=3'b001, mode=1 → result=3'b011, ovf=1, ovf_cnt increments.
- Assert rst for one cycle while in S_B with op_a=5 → state=00, op_a=0, counters 0. The next full sequence behaves normally.
- With CNT_W=2, run 5 overflowing operations → op_cnt=3, ovf_cnt=3, with no wrap.
